i2s_rcvr_frame_ctrl: RTL and testbench

//  Sequencing controller for the I2S receive datapath (edge detect + shift register).
//  - Syncs to the ws framing and issues clear/shift enables to the receive shift register.
//  - Captures left/right words into a stereo frame and hands it downstream via valid/ready.
//  - Flags short slots (sync loss) and frames dropped because downstream stalled (overrun).

---
 rtl/i2s_rcvr_frame_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_i2s_rcvr_frame_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rcvr_frame_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_rcvr_frame_ctrl
//
// Sequencing controller for an I2S receive datapath. It tracks the ws framing,
// drives clear/shift enables for an external receive shift register, gathers
// the left and right words into a stereo frame and presents that frame
// downstream through a valid/ready handshake.
//
// Ports
//   clk          bit clock (SCK), rising-edge logic
//   n_rst        asynchronous active-low reset
//   ws           word select; 0 = left slot, 1 = right slot
//   shift_data   parallel contents of the receive shift register (MSB first)
//   shift_clr    one-cycle clear of the shift register at each slot start
//   shift_en     shift enable, high for exactly WORD_W cycles per slot
//   left_data    left word of the presented frame
//   right_data   right word of the presented frame
//   frame_valid  left_data/right_data hold an unconsumed frame
//   frame_ready  downstream accepts the frame when high with frame_valid
//   overrun      sticky flag: a completed frame was dropped
//   ovr_clr      clears overrun (a same-cycle drop wins)
//   sync_err     one-cycle pulse: a slot ended with fewer than WORD_W bits
// ---------------------------------------------------------------------------
module i2s_rcvr_frame_ctrl #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ws,
    input  logic [WORD_W-1:0] shift_data,
    output logic              shift_clr,
    output logic              shift_en,
    output logic [WORD_W-1:0] left_data,
    output logic [WORD_W-1:0] right_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              sync_err
);

    localparam logic [CNT_W-1:0] WordCnt = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        StSync,
        StLeft,
        StRight
    } state_e;

    state_e state_q, state_d;

    logic              ws_q;
    logic              ws_edge;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              count_full;
    logic              slot_start;
    logic              slot_short;

    logic              shift_clr_q, shift_clr_d;
    logic              shift_en_q, shift_en_d;
    logic              sync_err_q, sync_err_d;
    logic              cap_q, cap_d;
    logic              cap_right_q, cap_right_d;

    logic [WORD_W-1:0] left_hold_q;
    logic [WORD_W-1:0] left_data_q;
    logic [WORD_W-1:0] right_data_q;
    logic              frame_valid_q;
    logic              overrun_q;

    logic              frame_done;
    logic              frame_load;
    logic              frame_drop;

    assign ws_edge    = ws ^ ws_q;
    // count tracks shift_en cycles issued so far, including the current one, so
    // an edge landing on the last data bit of a slot still sees a full slot.
    assign count_full = (count_q == WordCnt);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slot_start = 1'b0;
        slot_short = 1'b0;
        unique case (state_q)
            StSync: begin
                // Only a falling edge marks the start of a left slot.
                if (ws_edge && !ws) begin
                    state_d    = StLeft;
                    slot_start = 1'b1;
                end
            end
            StLeft, StRight: begin
                if (ws_edge) begin
                    if (count_full) begin
                        state_d    = ws ? StRight : StLeft;
                        slot_start = 1'b1;
                    end else begin
                        slot_short = 1'b1;
                        // A falling edge is itself a valid left-slot start.
                        if (!ws) begin
                            state_d    = StLeft;
                            slot_start = 1'b1;
                        end else begin
                            state_d = StSync;
                        end
                    end
                end
            end
            default: state_d = StSync;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / sequencing logic (all outputs are registered)
    // -----------------------------------------------------------------------
    always_comb begin
        shift_clr_d = slot_start;
        sync_err_d  = slot_short;
        shift_en_d  = 1'b0;
        count_d     = count_q;
        if (slot_start) begin
            shift_en_d = 1'b1;
            count_d    = CNT_W'(1);
        end else if (state_d == StSync) begin
            count_d = '0;
        end else if (shift_en_q && !count_full) begin
            shift_en_d = 1'b1;
            count_d    = count_q + CNT_W'(1);
        end
        // The last shift lands at the end of a full-count cycle, so the word is
        // complete on shift_data one cycle later (the capture cycle).
        cap_d       = shift_en_q && count_full;
        cap_right_d = (state_q == StRight);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ws_q        <= 1'b0;
            count_q     <= '0;
            shift_clr_q <= 1'b0;
            shift_en_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            cap_q       <= 1'b0;
            cap_right_q <= 1'b0;
        end else begin
            ws_q        <= ws;
            count_q     <= count_d;
            shift_clr_q <= shift_clr_d;
            shift_en_q  <= shift_en_d;
            sync_err_q  <= sync_err_d;
            cap_q       <= cap_d;
            cap_right_q <= cap_right_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame assembly and downstream handshake
    // -----------------------------------------------------------------------
    always_comb begin
        frame_done = cap_q && cap_right_q;
        frame_load = frame_done && (!frame_valid_q || frame_ready);
        frame_drop = frame_done && frame_valid_q && !frame_ready;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            left_hold_q   <= '0;
            left_data_q   <= '0;
            right_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (cap_q && !cap_right_q) begin
                left_hold_q <= shift_data;
            end
            // The right word goes straight from the shift register to the
            // output so the frame appears the cycle after the right capture.
            if (frame_load) begin
                left_data_q   <= left_hold_q;
                right_data_q  <= shift_data;
                frame_valid_q <= 1'b1;
            end else if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
            end
            if (frame_drop) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign shift_clr   = shift_clr_q;
    assign shift_en    = shift_en_q;
    assign sync_err    = sync_err_q;
    assign left_data   = left_data_q;
    assign right_data  = right_data_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_rcvr_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_rcvr_frame_ctrl
//
// Each segment is a precomputed ws / serial-data / ready / ovr_clr stream.
// Expected outputs per cycle are derived from that stream by walking the ws
// edges slot by slot, then replaying the valid/ready rules. The bench also
// plays the role of the receive shift register, driven by the DUT enables.
// Every segment ends with an asynchronous reset.
// ---------------------------------------------------------------------------
module tb_i2s_rcvr_frame_ctrl;

    localparam int W    = 16;
    localparam int MAXN = 1600;

    logic         clk         = 1'b0;
    logic         n_rst       = 1'b0;
    logic         ws          = 1'b0;
    logic [W-1:0] shift_data  = '0;
    logic         frame_ready = 1'b0;
    logic         ovr_clr     = 1'b0;
    logic         shift_clr;
    logic         shift_en;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         frame_valid;
    logic         overrun;
    logic         sync_err;

    i2s_rcvr_frame_ctrl #(
        .WORD_W(W),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ws         (ws),
        .shift_data (shift_data),
        .shift_clr  (shift_clr),
        .shift_en   (shift_en),
        .left_data  (left_data),
        .right_data (right_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int seg_id = 0;
    int seg_n  = 0;

    // Stimulus streams
    logic ws_arr  [MAXN];
    logic sd_arr  [MAXN];
    logic rdy_arr [MAXN];
    logic oc_arr  [MAXN];

    // Expected outputs, indexed by cycle
    logic         e_clr  [MAXN];
    logic         e_en   [MAXN];
    logic         e_serr [MAXN];
    logic         e_fv   [MAXN];
    logic         e_ovr  [MAXN];
    logic [W-1:0] e_ld   [MAXN];
    logic [W-1:0] e_rd   [MAXN];
    int           cap_kind [MAXN];  // 0 none, 1 left word complete, 2 right word complete
    logic [W-1:0] cap_word [MAXN];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s seg=%0d cyc=%0d: got %h expected %h", tag, seg_id, cyc, got, exp);
        end
    endtask

    task automatic seg_init(input int rdy_pct, input int oc_pct);
        seg_n = 0;
        for (int t = 0; t < MAXN; t++) begin
            ws_arr[t]  = 1'b0;
            sd_arr[t]  = 1'($urandom);
            rdy_arr[t] = (int'($urandom_range(0, 99)) < rdy_pct);
            oc_arr[t]  = (int'($urandom_range(0, 99)) < oc_pct);
        end
    endtask

    // Append a slot of len cycles at ws=level; the word is sent MSB first
    // starting one cycle after the slot's ws edge, truncated if the slot is short.
    task automatic add_slot(input logic level, input int len, input logic [W-1:0] word);
        int st;
        st = seg_n;
        for (int i = 0; i < len; i++) ws_arr[st + i] = level;
        for (int k = 0; k < W && k < len; k++) sd_arr[st + k + 1] = word[W-1-k];
        seg_n = st + len;
    endtask

    task automatic close_slot(input int s, input int e, input logic right, input bit full);
        logic [W-1:0] w;
        int last;
        last = (e < s + W) ? e : s + W;
        if (s + 1 < seg_n) e_clr[s + 1] = 1'b1;
        for (int u = s + 1; u <= last && u < seg_n; u++) e_en[u] = 1'b1;
        if (full && (s + W + 1 < seg_n)) begin
            for (int k = 0; k < W; k++) w[W-1-k] = sd_arr[s + 1 + k];
            cap_kind[s + W + 1] = right ? 2 : 1;
            cap_word[s + W + 1] = w;
        end
    endtask

    task automatic build_model();
        bit           synced;
        int           s;
        logic         right;
        logic         prev;
        logic         fv, ovr, drop;
        logic [W-1:0] ld, rd, lh;
        for (int t = 0; t < MAXN; t++) begin
            e_clr[t] = 1'b0; e_en[t] = 1'b0; e_serr[t] = 1'b0;
            e_fv[t] = 1'b0; e_ovr[t] = 1'b0; e_ld[t] = '0; e_rd[t] = '0;
            cap_kind[t] = 0; cap_word[t] = '0;
        end
        synced = 1'b0; s = 0; right = 1'b0; prev = 1'b0;
        for (int t = 0; t < seg_n; t++) begin
            if (ws_arr[t] != prev) begin
                if (synced) begin
                    if (t - s >= W) begin
                        close_slot(s, t, right, 1'b1);
                        s = t;
                        right = ws_arr[t];
                    end else begin
                        close_slot(s, t, right, 1'b0);
                        if (t + 1 < seg_n) e_serr[t + 1] = 1'b1;
                        if (!ws_arr[t]) begin
                            s = t;
                            right = 1'b0;
                        end else begin
                            synced = 1'b0;
                        end
                    end
                end else if (!ws_arr[t]) begin
                    synced = 1'b1;
                    s = t;
                    right = 1'b0;
                end
            end
            prev = ws_arr[t];
        end
        if (synced) close_slot(s, seg_n, right, 1'b1);

        fv = 1'b0; ovr = 1'b0; ld = '0; rd = '0; lh = '0;
        for (int t = 0; t < seg_n; t++) begin
            e_fv[t] = fv; e_ovr[t] = ovr; e_ld[t] = ld; e_rd[t] = rd;
            drop = 1'b0;
            if (cap_kind[t] == 1) lh = cap_word[t];
            if (cap_kind[t] == 2) begin
                if (!fv || rdy_arr[t]) begin
                    ld = lh;
                    rd = cap_word[t];
                    fv = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (fv && rdy_arr[t]) begin
                fv = 1'b0;
            end
            if (drop) ovr = 1'b1;
            else if (oc_arr[t]) ovr = 1'b0;
        end
    endtask

    task automatic run_segment();
        logic [W-1:0] sr;
        logic         clr_s, en_s;
        build_model();
        sr = '0;
        @(posedge clk);
        #1;
        for (int t = 0; t < seg_n; t++) begin
            cyc         = t;
            ws          = ws_arr[t];
            frame_ready = rdy_arr[t];
            ovr_clr     = oc_arr[t];
            shift_data  = sr;
            if (t == 0) n_rst = 1'b1;
            check_val("shift_clr",   32'(shift_clr),   32'(e_clr[t]));
            check_val("shift_en",    32'(shift_en),    32'(e_en[t]));
            check_val("sync_err",    32'(sync_err),    32'(e_serr[t]));
            check_val("frame_valid", 32'(frame_valid), 32'(e_fv[t]));
            check_val("overrun",     32'(overrun),     32'(e_ovr[t]));
            check_val("left_data",   32'(left_data),   32'(e_ld[t]));
            check_val("right_data",  32'(right_data),  32'(e_rd[t]));
            clr_s = shift_clr;
            en_s  = shift_en;
            @(posedge clk);
            #1;
            if (clr_s) sr = en_s ? {{(W-1){1'b0}}, sd_arr[t]} : '0;
            else if (en_s) sr = {sr[W-2:0], sd_arr[t]};
        end
        // Asynchronous reset between clock edges: outputs must drop at once.
        #2;
        n_rst = 1'b0;
        #1;
        cyc = seg_n;
        check_val("rst_shift_clr",   32'(shift_clr),   32'd0);
        check_val("rst_shift_en",    32'(shift_en),    32'd0);
        check_val("rst_sync_err",    32'(sync_err),    32'd0);
        check_val("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_val("rst_overrun",     32'(overrun),     32'd0);
        check_val("rst_left_data",   32'(left_data),   32'd0);
        check_val("rst_right_data",  32'(right_data),  32'd0);
        seg_id++;
    endtask

    initial begin
        int st;
        int len;
        logic lvl;

        // Long 32-clk slots after a leading ws=1 (rising edge only, must stay idle).
        seg_init(100, 0);
        add_slot(1'b1, 7, W'($urandom));
        add_slot(1'b0, 32, 16'hA5C3);
        add_slot(1'b1, 32, 16'h0FF0);
        add_slot(1'b0, 32, W'($urandom));
        add_slot(1'b1, 32, W'($urandom));
        add_slot(1'b0, 40, W'($urandom));
        run_segment();

        // Exactly WORD_W-clk slots back to back.
        seg_init(75, 0);
        add_slot(1'b1, 3, W'($urandom));
        for (int i = 0; i < 8; i++) begin
            add_slot(1'b0, W, W'($urandom));
            add_slot(1'b1, W, W'($urandom));
        end
        add_slot(1'b0, 20, W'($urandom));
        run_segment();

        // Downstream stalls across three frames, then recovers; ovr_clr pulses,
        // one of them coinciding with a dropped frame.
        seg_init(0, 0);
        add_slot(1'b1, 3, W'($urandom));
        for (int i = 0; i < 4; i++) begin
            add_slot(1'b0, 32, W'($urandom));
            add_slot(1'b1, 32, W'($urandom));
        end
        add_slot(1'b0, 20, W'($urandom));
        for (int t = 200; t < MAXN; t++) rdy_arr[t] = 1'b1;
        oc_arr[116] = 1'b1;
        oc_arr[205] = 1'b1;
        run_segment();

        // Short right slot (falling resync) and short left slot (back to idle).
        seg_init(90, 0);
        add_slot(1'b1, 2, W'($urandom));
        add_slot(1'b0, 24, W'($urandom));
        add_slot(1'b1, 10, W'($urandom));
        add_slot(1'b0, 24, W'($urandom));
        add_slot(1'b1, 24, W'($urandom));
        add_slot(1'b0, 5, W'($urandom));
        add_slot(1'b1, 20, W'($urandom));
        add_slot(1'b0, 20, W'($urandom));
        add_slot(1'b1, 20, W'($urandom));
        add_slot(1'b0, 30, W'($urandom));
        run_segment();

        // Random slot lengths, ready and ovr_clr; reset lands mid left slot.
        seg_init(50, 3);
        add_slot(1'b1, 2, W'($urandom));
        lvl = 1'b0;
        for (int i = 0; i < 30; i++) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15))
                                               : int'($urandom_range(16, 36));
            add_slot(lvl, len, W'($urandom));
            lvl = ~lvl;
        end
        if (lvl) add_slot(1'b1, 20, W'($urandom));
        st = seg_n;
        add_slot(1'b0, 40, W'($urandom));
        seg_n = st + 9;
        run_segment();

        // Clean resync after the mid-slot reset.
        seg_init(80, 0);
        add_slot(1'b1, 4, W'($urandom));
        for (int i = 0; i < 3; i++) begin
            add_slot(1'b0, 20, W'($urandom));
            add_slot(1'b1, 20, W'($urandom));
        end
        add_slot(1'b0, 24, W'($urandom));
        run_segment();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
